// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32/RV64 decode stage with a 2-entry skid buffer
// Splits fields, builds the sign-extended immediate and classifies the format at capture time.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;
  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic            accept;
  logic            load_ok;

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign load_ok  = !out_valid | out_ready;

  // The skid entry is always older than anything on the input, so it wins the output register.
  always_comb begin
    src_instr = skid_valid ? skid_instr : in_instr;
    src_pc    = skid_valid ? skid_pc : in_pc;
    dec_fmt   = FMT_ILL;
    dec_imm32 = 32'd0;
    case (src_instr[6:0])
      7'b0110011: dec_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: dec_fmt = FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      default:    dec_fmt = FMT_ILL;
    endcase
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{src_instr[31]}}, src_instr[31:20]};
      FMT_S: dec_imm32 = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
      FMT_B: dec_imm32 = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25],
                          src_instr[11:8], 1'b0};
      FMT_U: dec_imm32 = {src_instr[31:12], 12'd0};
      FMT_J: dec_imm32 = {{12{src_instr[31]}}, src_instr[19:12], src_instr[20],
                          src_instr[30:21], 1'b0};
      default: dec_imm32 = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      out_pc     <= '0;
      opcode     <= '0;
      rd         <= '0;
      funct3     <= '0;
      rs1        <= '0;
      rs2        <= '0;
      funct7     <= '0;
      imm        <= '0;
      fmt        <= FMT_R;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_ok) begin
      if (skid_valid || accept) begin
        out_valid <= 1'b1;
        out_pc    <= src_pc;
        opcode    <= src_instr[6:0];
        rd        <= src_instr[11:7];
        funct3    <= src_instr[14:12];
        rs1       <= src_instr[19:15];
        rs2       <= src_instr[24:20];
        funct7    <= src_instr[31:25];
        imm       <= XLEN'($signed(dec_imm32));
        fmt       <= dec_fmt;
        illegal   <= (dec_fmt == FMT_ILL);
      end else begin
        out_valid <= 1'b0;
      end
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed bench for decode_stage at XLEN=32 and XLEN=64
// Both instances see identical stimulus; expectations are hand-computed constants.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3, a_fmt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2),
    .funct7(a_funct7), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal)
  );

  decode_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2),
    .funct7(b_funct7), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // Single instruction into an empty stage; returns with it in the output register.
  task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
    present(instr, pc);
    step();
    in_valid = 1'b0;
  endtask

  task automatic fill_skid;
    out_ready = 1'b0;
    present(32'h00100093, 64'h300);
    step();
    present(32'h00200113, 64'h304);
    step();
    present(32'h00300193, 64'h308);
    check("fill_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("fill_out_pc", {32'd0, a_out_pc}, 64'h300);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst_fmt", {61'd0, a_fmt}, 64'd0);
    check("rst_illegal", {63'd0, a_illegal}, 64'd0);
    check("rst_imm64", b_imm, 64'd0);

    // addi x1,x2,-1
    issue(32'hFFF10093, 64'h100);
    check("addi_valid", {63'd0, a_out_valid}, 64'd1);
    check("addi_opcode", {57'd0, a_opcode}, 64'h13);
    check("addi_rd", {59'd0, a_rd}, 64'd1);
    check("addi_rs1", {59'd0, a_rs1}, 64'd2);
    check("addi_funct3", {61'd0, a_funct3}, 64'd0);
    check("addi_imm32", {32'd0, a_imm}, 64'hFFFFFFFF);
    check("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
    check("addi_fmt", {61'd0, a_fmt}, 64'd1);
    check("addi_pc", {32'd0, a_out_pc}, 64'h100);

    // beq x0,x0,-4
    issue(32'hFE000EE3, 64'h104);
    check("beq_fmt", {61'd0, a_fmt}, 64'd3);
    check("beq_imm32", {32'd0, a_imm}, 64'hFFFFFFFC);
    check("beq_rs1", {59'd0, a_rs1}, 64'd0);
    check("beq_rs2", {59'd0, a_rs2}, 64'd0);
    check("beq_illegal", {63'd0, a_illegal}, 64'd0);

    // lui x5,0x80000
    issue(32'h800002B7, 64'h108);
    check("lui_rd", {59'd0, b_rd}, 64'd5);
    check("lui_fmt", {61'd0, b_fmt}, 64'd4);
    check("lui_imm64", b_imm, 64'hFFFFFFFF80000000);
    check("lui_imm32", {32'd0, a_imm}, 64'h80000000);

    // sw x5,8(x2)
    issue(32'h00512423, 64'h10C);
    check("sw_fmt", {61'd0, a_fmt}, 64'd2);
    check("sw_imm64", b_imm, 64'd8);
    check("sw_rs2", {59'd0, a_rs2}, 64'd5);

    // jal x0,-8
    issue(32'hFF9FF06F, 64'h110);
    check("jal_fmt", {61'd0, a_fmt}, 64'd5);
    check("jal_imm32", {32'd0, a_imm}, 64'hFFFFFFF8);

    // add x3,x1,x2
    issue(32'h002081B3, 64'h114);
    check("add_fmt", {61'd0, a_fmt}, 64'd0);
    check("add_imm64", b_imm, 64'd0);
    check("add_rd", {59'd0, a_rd}, 64'd3);

    issue(32'h00000000, 64'h118);
    check("zero_illegal", {63'd0, a_illegal}, 64'd1);
    check("zero_fmt", {61'd0, a_fmt}, 64'd7);
    check("zero_imm64", b_imm, 64'd0);
    issue(32'h0000007F, 64'h11C);
    check("7f_illegal", {63'd0, b_illegal}, 64'd1);
    check("7f_fmt", {61'd0, b_fmt}, 64'd7);
    check("7f_imm32", {32'd0, a_imm}, 64'd0);
    step();
    check("drain_valid", {63'd0, a_out_valid}, 64'd0);

    // Back-pressure: A in output, B in skid, C held by the source
    out_ready = 1'b0;
    present(32'h00A00093, 64'h200);
    step();
    present(32'h00B00093, 64'h204);
    step();
    present(32'h00C00093, 64'h208);
    step();
    check("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("bp_hold_pc", {32'd0, a_out_pc}, 64'h200);
    check("bp_hold_imm", {32'd0, a_imm}, 64'hA);
    out_ready = 1'b1;
    #1;
    check("bp_a_valid", {63'd0, a_out_valid}, 64'd1);
    check("bp_a_pc", {32'd0, a_out_pc}, 64'h200);
    step();
    check("bp_b_pc", {32'd0, a_out_pc}, 64'h204);
    check("bp_b_imm", b_imm, 64'hB);
    check("bp_b_in_ready", {63'd0, a_in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_c_pc", {32'd0, a_out_pc}, 64'h208);
    check("bp_c_valid", {63'd0, a_out_valid}, 64'd1);
    step();
    check("bp_end_valid", {63'd0, a_out_valid}, 64'd0);

    // Flush with skid full
    fill_skid();
    flush = 1'b1;
    #1;
    check("flush_cycle_in_ready", {63'd0, a_in_ready}, 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    issue(32'h00D00093, 64'h400);
    check("post_flush_valid", {63'd0, a_out_valid}, 64'd1);
    check("post_flush_pc", {32'd0, a_out_pc}, 64'h400);

    // Input presented during flush must not be captured
    present(32'h00E00093, 64'h404);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_nocap_valid", {63'd0, b_out_valid}, 64'd0);
    step();
    check("flush_nocap_valid2", {63'd0, b_out_valid}, 64'd0);

    // Same sequence with reset
    fill_skid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rst2_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst2_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst2_imm64", b_imm, 64'd0);
    issue(32'hFFF10093, 64'h500);
    check("post_rst_valid", {63'd0, b_out_valid}, 64'd1);
    check("post_rst_pc", b_out_pc, 64'h500);
    check("post_rst_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
